// File: rtl/mips32_pkg.sv
// Shared fetch-path types and constants: instruction width, the NOP word and
// the response entry carried from the store read to the consumer.
package mips32_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h00000000;
  localparam int FETCH_FIFO_DEPTH = 3;

  typedef struct packed {
    logic               err;
    logic [31:0]        addr;
    logic [INSTR_W-1:0] instr;
  } fetch_rsp_t;

endpackage

// File: rtl/fetch_rsp_fifo.sv
// Small circular buffer of fetch responses with occupancy count and a flush
// that empties it in one edge, discarding any same-edge push or pop.
module fetch_rsp_fifo
  import mips32_pkg::*;
#(
  parameter int DEPTH = FETCH_FIFO_DEPTH,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  fetch_rsp_t       push_data,
  input  logic             pop,
  output fetch_rsp_t       head,
  output logic [CNT_W-1:0] count
);

  fetch_rsp_t       entry_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             empty, full, do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = entry_reg[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      // Pointers wrap explicitly so non-power-of-two depths work.
      if (do_push)
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      if (do_pop)
        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      entry_reg[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_responder.sv
// Two-stage instruction fetch responder: S1 holds the accepted address while
// the store read completes, then the result is buffered in a response FIFO.
module instr_fetch_responder
  import mips32_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_addr,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [INSTR_W-1:0] rsp_instr,
  output logic [31:0]        rsp_addr,
  output logic               rsp_err,
  input  logic               flush,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  output logic               busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [INSTR_W-1:0] store_mem [2**ADDR_W];
  logic [INSTR_W-1:0] rd_data_reg;

  logic        s1_valid_reg, s1_err_reg;
  logic [31:0] s1_addr_reg;

  logic             accept, consume, req_err, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occupancy;
  fetch_rsp_t       push_entry, head_entry;

  // Space is reserved for the S1 entry too, so S1 can always drain next edge.
  assign occupancy  = {1'b0, fifo_count} + (CNT_W + 1)'(s1_valid_reg);
  assign req_ready  = !reset && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
  assign accept     = req_valid && req_ready;
  assign req_err    = |req_addr[31:ADDR_W];
  assign fifo_empty = (fifo_count == '0);
  assign consume    = rsp_valid && rsp_ready;

  // Store read happens at the accept edge; the nonblocking write gives
  // read-before-write when a load targets the word being fetched.
  always_ff @(posedge clk) begin
    if (load_en)
      store_mem[load_addr] <= load_data;
    if (accept && !req_err)
      rd_data_reg <= store_mem[req_addr[ADDR_W-1:0]];
  end

  // A handshake coincident with flush is the redirect target, so it is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_err_reg   <= 1'b0;
      s1_addr_reg  <= '0;
    end else begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_err_reg  <= req_err;
        s1_addr_reg <= req_addr;
      end
    end
  end

  always_comb begin
    push_entry.err   = s1_err_reg;
    push_entry.addr  = s1_addr_reg;
    push_entry.instr = s1_err_reg ? NOP_WORD : rd_data_reg;
  end

  fetch_rsp_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (s1_valid_reg),
    .push_data (push_entry),
    .pop       (consume),
    .head      (head_entry),
    .count     (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_instr = rsp_valid ? head_entry.instr : '0;
  assign rsp_addr  = rsp_valid ? head_entry.addr  : '0;
  assign rsp_err   = rsp_valid && head_entry.err;
  assign busy      = s1_valid_reg || !fifo_empty;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Scoreboard bench for instr_fetch_responder: the driver queues expected
// responses on accept, a negedge monitor pops and compares on each handshake.
module tb_instr_fetch_responder;
  import mips32_pkg::*;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [31:0]       req_addr = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_instr;
  logic [31:0]       rsp_addr;
  logic              rsp_err;
  logic              flush = 1'b0;
  logic              load_en = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [31:0]       load_data = '0;
  logic              busy;

  instr_fetch_responder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .flush     (flush),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [31:0] prog [6] = '{32'h20010001, 32'h20020002, 32'h00221820,
                            32'hAC030004, 32'h8C040008, 32'h1000FFFF};

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  fetch_rsp_t exp_q[$];
  int         pop_cyc[$];
  fetch_rsp_t mon_e;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got addr %h instr %h, expected no response", rsp_addr, rsp_instr);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_addr", rsp_addr, mon_e.addr);
          check("rsp_instr", rsp_instr, mon_e.instr);
          check("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
          $display("rsp cyc=%0d addr=%h instr=%h err=%0d", cyc, rsp_addr, rsp_instr, rsp_err);
        end
        pop_cyc.push_back(cyc);
      end else if (!rsp_valid) begin
        check("idle_outputs_zero", rsp_instr | rsp_addr | {31'b0, rsp_err}, 32'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] ei, input logic ee, output bit acc);
    req_valid = 1'b1;
    req_addr  = a;
    acc = req_ready;
    if (acc) exp_q.push_back('{err: ee, addr: a, instr: ei});
    step();
    req_valid = 1'b0;
  endtask

  task automatic issue_wait(input logic [31:0] a, input logic [31:0] ei, input logic ee);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) issue(a, ei, ee, acc);
    check("accept_timeout", {31'b0, acc}, 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) step();
    check("drain_remaining", exp_q.size(), 0);
    step();
    check("busy_after_drain", {31'b0, busy}, 32'd0);
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en = 1'b0;
  endtask

  initial begin
    int p0, first_acc, acc_n, a;
    bit acc;

    // Reset state, asserted asynchronously before any clock edge.
    #1 reset = 1'b1;
    #1;
    check("reset_rsp_valid", {31'b0, rsp_valid}, 0);
    check("reset_req_ready", {31'b0, req_ready}, 0);
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_rsp_bus", rsp_instr | rsp_addr | {31'b0, rsp_err}, 0);
    step();
    step();
    reset = 1'b0;
    step();
    check("ready_after_release", {31'b0, req_ready}, 1);

    for (int i = 0; i < 6; i++) load(ADDR_W'(i), prog[i]);
    load(10'h3FF, 32'h03E00008);

    // Back-to-back fetch with latency and consecutive-cycle checks.
    rsp_ready = 1'b1;
    p0 = pop_cyc.size();
    first_acc = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      issue(i, prog[i], 1'b0, acc);
      check("b2b_accept", {31'b0, acc}, 1);
    end
    drain();
    check("b2b_count", pop_cyc.size() - p0, 4);
    if (pop_cyc.size() - p0 == 4) begin
      check("first_latency", pop_cyc[p0], first_acc + 1);
      for (int k = 1; k < 4; k++) check("consecutive", pop_cyc[p0 + k], pop_cyc[p0] + k);
    end

    // Backpressure: only three entries fit before req_ready drops.
    rsp_ready = 1'b0;
    p0 = pop_cyc.size();
    acc_n = 0;
    a = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1;
      req_addr = a;
      if (req_ready) begin
        exp_q.push_back('{err: 1'b0, addr: a, instr: prog[a]});
        acc_n++;
        a++;
      end
      step();
    end
    req_valid = 1'b0;
    check("bp_accepted", acc_n, 3);
    check("bp_req_ready", {31'b0, req_ready}, 0);
    check("bp_busy", {31'b0, busy}, 1);
    rsp_ready = 1'b1;
    while (a < 6) begin
      issue_wait(a, prog[a], 1'b0);
      a++;
    end
    drain();
    check("bp_count", pop_cyc.size() - p0, 6);

    // Out-of-range and top-of-store boundary.
    issue_wait(32'h00000400, NOP_WORD, 1'b1);
    issue_wait(32'h000003FF, 32'h03E00008, 1'b0);
    issue_wait(32'hFFFFFFFF, NOP_WORD, 1'b1);
    drain();

    // Flush with simultaneous redirect to address 3.
    rsp_ready = 1'b0;
    issue_wait(0, prog[0], 1'b0);
    issue_wait(1, prog[1], 1'b0);
    p0 = pop_cyc.size();
    check("flush_ready", {31'b0, req_ready}, 1);
    flush = 1'b1;
    req_valid = 1'b1;
    req_addr = 32'd3;
    exp_q.delete();
    if (req_ready) exp_q.push_back('{err: 1'b0, addr: 32'd3, instr: 32'hAC030004});
    step();
    flush = 1'b0;
    req_valid = 1'b0;
    check("flush_keeps_redirect", {31'b0, busy}, 1);
    rsp_ready = 1'b1;
    drain();
    check("flush_count", pop_cyc.size() - p0, 1);

    // Flush alone empties everything.
    rsp_ready = 1'b0;
    issue_wait(0, prog[0], 1'b0);
    issue_wait(1, prog[1], 1'b0);
    flush = 1'b1;
    exp_q.delete();
    step();
    flush = 1'b0;
    check("flush_rsp_valid", {31'b0, rsp_valid}, 0);
    check("flush_busy", {31'b0, busy}, 0);
    rsp_ready = 1'b1;
    repeat (3) step();
    check("flush_no_stale", {31'b0, rsp_valid}, 0);

    // Load and fetch of the same word in one cycle: old word first.
    load_en = 1'b1;
    load_addr = 10'd2;
    load_data = 32'hFFFFFFFF;
    issue(2, 32'h00221820, 1'b0, acc);
    load_en = 1'b0;
    check("rbw_accept", {31'b0, acc}, 1);
    issue_wait(2, 32'hFFFFFFFF, 1'b0);
    drain();

    // Asynchronous reset with two buffered entries.
    rsp_ready = 1'b0;
    issue_wait(0, prog[0], 1'b0);
    issue_wait(1, prog[1], 1'b0);
    step();
    check("prereset_busy", {31'b0, busy}, 1);
    check("prereset_valid", {31'b0, rsp_valid}, 1);
    #1 reset = 1'b1;
    #1;
    check("async_rsp_valid", {31'b0, rsp_valid}, 0);
    check("async_busy", {31'b0, busy}, 0);
    check("async_req_ready", {31'b0, req_ready}, 0);
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) step();
    check("no_stale_after_reset", {31'b0, rsp_valid}, 0);
    issue_wait(0, 32'h20010001, 1'b0);
    issue_wait(2, 32'hFFFFFFFF, 1'b0);
    issue_wait(3, 32'hAC030004, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded");
    $fatal(1, "timeout");
  end

endmodule
